// File: rtl/button_reader.sv
// button_reader: synchronized, debounced push-button with short/long press event channel and drop pulse.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int LONG_CYCLES     = 8000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  input  logic EVT_READY,
  output logic PRESSED,
  output logic EVT_VALID,
  output logic EVT_LONG,
  output logic EVT_DROP
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] DUR_MAX = LW'(LONG_CYCLES);
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [DW-1:0] db_cnt, db_n;
  logic [LW-1:0] dur, dur_n;
  logic act, pressed_n, commit, hs;
  assign act = sync[1] ^ BTN_ACTIVE_LOW;
  assign hs  = EVT_VALID & EVT_READY;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sync    <= {2{BTN_ACTIVE_LOW}};
      state   <= IDLE;
      db_cnt  <= '0;
      dur     <= '0;
      PRESSED <= 1'b0;
    end else begin
      sync    <= {sync[0], BTN};
      state   <= state_n;
      db_cnt  <= db_n;
      dur     <= dur_n;
      PRESSED <= pressed_n;
    end
  always_comb begin
    state_n   = state;
    db_n      = db_cnt;
    pressed_n = PRESSED;
    commit    = 1'b0;
    dur_n     = (state == HELD || state == DB_REL) && dur != DUR_MAX ? dur + 1'b1 : dur;
    case (state)
      IDLE: if (act) begin
        state_n = DB_PRESS;
        db_n    = '0;
      end
      DB_PRESS: if (!act) state_n = IDLE;
        else if (db_cnt == DB_LAST) begin
          state_n   = HELD;
          pressed_n = 1'b1;
          dur_n     = '0;
        end else db_n = db_cnt + 1'b1;
      HELD: if (!act) begin
        state_n = DB_REL;
        db_n    = '0;
      end
      DB_REL: if (act) state_n = HELD;
        else if (db_cnt == DB_LAST) begin
          state_n   = IDLE;
          pressed_n = 1'b0;
          commit    = 1'b1;
        end else db_n = db_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // A handshake in the commit cycle frees the slot, so the new event replaces the old one.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      EVT_VALID <= 1'b0;
      EVT_LONG  <= 1'b0;
      EVT_DROP  <= 1'b0;
    end else begin
      EVT_DROP <= commit & EVT_VALID & ~hs;
      if (commit && (!EVT_VALID || hs)) begin
        EVT_VALID <= 1'b1;
        EVT_LONG  <= dur >= DUR_MAX;
      end else if (hs) EVT_VALID <= 1'b0;
    end
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed and random stimulus against a sliding-window behavioural model.
module tb_button_reader;
  localparam int DB = 4;
  localparam int LG = 20;
  logic CLK = 1'b0, RST_N = 1'b0, BTN = 1'b1, EVT_READY = 1'b0;
  logic PRESSED, EVT_VALID, EVT_LONG, EVT_DROP;
  int checks = 0, errors = 0;
  bit b1, b2, mp, mv, ml, md, any_act;
  bit hist [DB+1];
  int dur, dut_drops, dut_evts, r;
  logic prev_v = 1'b0;
  always #5 CLK = ~CLK;
  button_reader #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .BTN_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN), .EVT_READY(EVT_READY),
    .PRESSED(PRESSED), .EVT_VALID(EVT_VALID), .EVT_LONG(EVT_LONG), .EVT_DROP(EVT_DROP)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  // PRESSED toggles once the last DB+1 synchronized samples all disagree with it.
  task automatic model();
    bit act, opp, commit, cl, hs;
    if (!RST_N) begin
      b1 = 1; b2 = 1; mp = 0; mv = 0; ml = 0; md = 0; dur = 0;
      foreach (hist[i]) hist[i] = 0;
      return;
    end
    act = !b2; b2 = b1; b1 = BTN;
    for (int i = DB; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = act;
    opp = 1;
    foreach (hist[i]) if (hist[i] == mp) opp = 0;
    commit = 0; cl = 0;
    if (opp && mp) begin commit = 1; cl = dur >= LG; mp = 0; end
    else if (opp) begin mp = 1; dur = 0; end
    else if (mp) dur = dur < LG ? dur + 1 : LG;
    hs = mv && EVT_READY;
    md = 0;
    if (commit && (!mv || hs)) begin mv = 1; ml = cl; end
    else if (commit) md = 1;
    else if (hs) mv = 0;
  endtask
  task automatic cyc();
    @(posedge CLK);
    model();
    @(negedge CLK);
    chk("pressed", PRESSED, mp);
    chk("valid", EVT_VALID, mv);
    chk("drop", EVT_DROP, md);
    if (mv) chk("long", EVT_LONG, ml);
    if (EVT_DROP) dut_drops++;
    if (EVT_VALID && !prev_v) dut_evts++;
    if (PRESSED || EVT_VALID) any_act = 1;
    prev_v = EVT_VALID;
  endtask
  task automatic hold(input logic lvl, input int n);
    BTN = lvl;
    repeat (n) cyc();
  endtask
  task automatic measure(input int n, output int rise);
    rise = -1;
    for (int k = 1; k <= n; k++) begin
      cyc();
      if (PRESSED && rise < 0) rise = k;
    end
  endtask
  task automatic consume();
    EVT_READY = 1; cyc(); EVT_READY = 0;
    chk("consumed", EVT_VALID, 0);
  endtask
  initial begin
    int e0;
    repeat (3) cyc();
    chk("rst_pressed", PRESSED, 0);
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_long", EVT_LONG, 0);
    chk("rst_drop", EVT_DROP, 0);
    RST_N = 1;
    hold(1, 3);
    // clean short press
    BTN = 0; measure(12, r);
    chk("rise_latency", r, 7);
    hold(1, 10);
    chk("short_valid", EVT_VALID, 1);
    chk("short_long", EVT_LONG, 0);
    consume();
    // glitch
    any_act = 0;
    hold(0, 3); hold(1, 10);
    chk("glitch_quiet", any_act, 0);
    // long press with backpressure
    hold(0, 40); hold(1, 10);
    chk("long_valid", EVT_VALID, 1);
    chk("long_long", EVT_LONG, 1);
    hold(1, 5);
    chk("long_held", EVT_VALID, 1);
    consume();
    // release bounce: gaps lengthen the hold past the long threshold
    e0 = dut_evts;
    hold(0, 6); hold(1, 2); hold(0, 6); hold(1, 2); hold(0, 6);
    chk("bounce_pressed", PRESSED, 1);
    hold(1, 10);
    chk("bounce_events", dut_evts - e0, 1);
    chk("bounce_long", EVT_LONG, 1);
    consume();
    // backpressure: short then long with no ready
    e0 = dut_drops;
    hold(0, 8); hold(1, 10); hold(0, 30); hold(1, 10);
    chk("bp_long", EVT_LONG, 0);
    chk("bp_drops", dut_drops - e0, 1);
    hold(0, 30);
    BTN = 1; repeat (6) cyc();
    EVT_READY = 1; cyc(); EVT_READY = 0;
    chk("bp_hs_valid", EVT_VALID, 1);
    chk("bp_hs_long", EVT_LONG, 1);
    chk("bp_hs_drops", dut_drops - e0, 1);
    consume();
    // reset mid-hold
    e0 = dut_evts;
    hold(0, 8);
    RST_N = 0; #1;
    chk("mid_rst_pressed", PRESSED, 0);
    chk("mid_rst_valid", EVT_VALID, 0);
    BTN = 1; repeat (3) cyc();
    RST_N = 1;
    hold(1, 15);
    chk("mid_rst_events", dut_evts - e0, 0);
    // reset released while held needs a full debounce
    hold(0, 2);
    RST_N = 0; repeat (2) cyc(); RST_N = 1;
    measure(12, r);
    chk("post_rst_latency", r, 7);
    hold(1, 10);
    consume();
    for (int n = 0; n < 3000;) begin
      int len;
      BTN = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : $urandom_range(1, 30);
      for (int k = 0; k < len; k++, n++) begin
        EVT_READY = $urandom_range(0, 3) == 0;
        cyc();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
